// File: rtl/cache_mem_arbiter_pkg.sv
// Shared core types for the cache/memory arbiter: Avalon request/response
// structs, the arbiter FSM state and the port-index width.
package cache_mem_arbiter_pkg;
  localparam int AVN_ADDR_W = 32;
  localparam int AVN_DATA_W = 32;
  localparam int AVN_BE_W   = 4;
  localparam int ARB_IDX_W  = 2;

  typedef struct packed {
    logic                  read;
    logic                  write;
    logic [AVN_ADDR_W-1:0] address;
    logic [AVN_BE_W-1:0]   byte_enable;
    logic [AVN_DATA_W-1:0] writedata;
  } avalon_req_t;

  typedef struct packed {
    logic [AVN_DATA_W-1:0] readdata;
    logic                  waitrequest;
  } avalon_resp_t;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

  // Round-robin successor of a port index, wrapping at n.
  function automatic logic [ARB_IDX_W-1:0] next_idx(input logic [ARB_IDX_W-1:0] idx, input int n);
    return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
  endfunction
endpackage

// File: rtl/cache_mem_arbiter_rr_arbiter.sv
// Round-robin grant: search starts at ptr and wraps; one-hot grant out.
module rr_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ARB_IDX_W-1:0] ptr,
  output logic [NUM_PORTS-1:0] gnt
);
  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(ptr) + k) % NUM_PORTS;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (!found && j == idx && req[j]) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates NUM_PORTS cache Avalon masters onto one memory port; grants lock
// while memory stalls. Define ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  avalon_req_t  [NUM_PORTS-1:0]  port_avn_req,
  output avalon_resp_t [NUM_PORTS-1:0]  port_avn_resp,
  output avalon_req_t                   mem_avn_req,
  input  avalon_resp_t                  mem_avn_resp,
  output logic                          timeout_err
);
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 2);

  arb_state_t           state_q, state_d;
  logic [ARB_IDX_W-1:0] owner_q, owner_d;
  logic [ARB_IDX_W-1:0] rd_owner_q, rd_owner_d;
  logic                 rd_pending_q, rd_pending_d;
  logic [CNT_W-1:0]     lock_cnt_q, lock_cnt_d;

  logic [NUM_PORTS-1:0] req_vec;
  logic                 idle_vld, gnt_vld, xfer_acc, timeout;
  logic [ARB_IDX_W-1:0] idle_idx, gnt_idx;
  avalon_req_t          gnt_req;

  always_comb
    for (int i = 0; i < NUM_PORTS; i++) req_vec[i] = port_avn_req[i].read | port_avn_req[i].write;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ARB_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0] rr_gnt;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr_arbiter (.req(req_vec), .ptr(rr_ptr_q), .gnt(rr_gnt));

  always_comb begin
    idle_vld = |rr_gnt;
    idle_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) if (rr_gnt[i]) idle_idx = ARB_IDX_W'(i);
    rr_ptr_d = xfer_acc ? next_idx(gnt_idx, NUM_PORTS) : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
`else
  always_comb begin
    idle_vld = |req_vec;
    idle_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) if (req_vec[i]) idle_idx = ARB_IDX_W'(i);
  end
`endif

  // A locked owner is forwarded whether or not a higher-priority port has appeared.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (state_q == ARB_LOCK) begin
      gnt_vld = 1'b1;
      gnt_idx = owner_q;
    end else if (idle_vld) begin
      gnt_vld = 1'b1;
      gnt_idx = idle_idx;
    end
    gnt_req = port_avn_req[0];
    for (int i = 0; i < NUM_PORTS; i++) if (gnt_idx == ARB_IDX_W'(i)) gnt_req = port_avn_req[i];
    xfer_acc = gnt_vld & ~mem_avn_resp.waitrequest;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      rd_owner_q   <= '0;
      rd_pending_q <= 1'b0;
      lock_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rd_owner_q   <= rd_owner_d;
      rd_pending_q <= rd_pending_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lock_cnt_d   = lock_cnt_q;
    timeout      = 1'b0;
    rd_pending_d = xfer_acc & gnt_req.read;
    rd_owner_d   = (xfer_acc & gnt_req.read) ? gnt_idx : rd_owner_q;
    case (state_q)
      ARB_IDLE: begin
        lock_cnt_d = '0;
        if (gnt_vld && mem_avn_resp.waitrequest) begin
          state_d = ARB_LOCK;
          owner_d = gnt_idx;
        end
      end
      ARB_LOCK: begin
        if (!mem_avn_resp.waitrequest) begin
          state_d    = ARB_IDLE;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
          // Timeout drops the lock only; the master's request stays up and re-arbitrates.
          if (LOCK_TIMEOUT != 0 && lock_cnt_d == CNT_W'(LOCK_TIMEOUT)) begin
            timeout    = 1'b1;
            state_d    = ARB_IDLE;
            lock_cnt_d = '0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    mem_avn_req       = port_avn_req[0];
    mem_avn_req.read  = 1'b0;
    mem_avn_req.write = 1'b0;
    if (gnt_vld) mem_avn_req = gnt_req;
    timeout_err = timeout;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_avn_resp[i].waitrequest = req_vec[i];
      port_avn_resp[i].readdata    = '0;
      if (gnt_vld && gnt_idx == ARB_IDX_W'(i)) port_avn_resp[i].waitrequest = mem_avn_resp.waitrequest;
      if (rd_pending_q && rd_owner_q == ARB_IDX_W'(i)) port_avn_resp[i].readdata = mem_avn_resp.readdata;
    end
    if (!rst_n) begin
      mem_avn_req.read  = 1'b0;
      mem_avn_req.write = 1'b0;
      timeout_err       = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) port_avn_resp[i].waitrequest = 1'b1;
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter (2 ports, LOCK_TIMEOUT=4).
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  avalon_req_t  [1:0] preq;
  avalon_resp_t [1:0] presp;
  avalon_req_t        mreq;
  avalon_resp_t       mresp;
  logic               tmo;
  int                 checks = 0;
  int                 failures = 0;

  cache_mem_arbiter #(.NUM_PORTS(2), .LOCK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .port_avn_req(preq), .port_avn_resp(presp),
    .mem_avn_req(mreq), .mem_avn_resp(mresp), .timeout_err(tmo)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus at the falling edge, settle, then caller checks.
  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0,
                       input logic r1, input logic w1, input logic [31:0] a1,
                       input logic mw, input logic [31:0] rd);
    @(negedge clk);
    preq[0].read = r0; preq[0].write = w0; preq[0].address = a0;
    preq[0].byte_enable = 4'hF; preq[0].writedata = 32'h1111_0000;
    preq[1].read = r1; preq[1].write = w1; preq[1].address = a1;
    preq[1].byte_enable = 4'hF; preq[1].writedata = 32'h2222_0000;
    mresp.waitrequest = mw; mresp.readdata = rd;
    #1;
  endtask

  task automatic test_reset;
    drive(1, 0, 32'h10, 1, 0, 32'h20, 0, 32'h0);
    checks++; if (mreq.read !== 1'b0) begin failures++; $display("FAIL rst_mem_read got=%b exp=0", mreq.read); end
    checks++; if (presp[0].waitrequest !== 1'b1) begin failures++; $display("FAIL rst_wait0 got=%b exp=1", presp[0].waitrequest); end
    checks++; if (presp[1].waitrequest !== 1'b1) begin failures++; $display("FAIL rst_wait1 got=%b exp=1", presp[1].waitrequest); end
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%b exp=0", tmo); end
    @(negedge clk);
    rst_n = 1'b1;
    // First clock after release arbitrates immediately.
    #1;
    checks++; if (mreq.read !== 1'b1 || mreq.address !== 32'h10) begin failures++; $display("FAIL first_arb got=%b/%h exp=1/00000010", mreq.read, mreq.address); end
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  task automatic test_round_robin;
    drive(1, 0, 32'h10, 1, 0, 32'h20, 0, 32'h0);
    checks++; if (mreq.address !== 32'h10) begin failures++; $display("FAIL rr_c1_addr got=%h exp=00000010", mreq.address); end
    checks++; if (presp[1].waitrequest !== 1'b1) begin failures++; $display("FAIL rr_c1_wait1 got=%b exp=1", presp[1].waitrequest); end
    checks++; if (presp[0].waitrequest !== 1'b0) begin failures++; $display("FAIL rr_c1_wait0 got=%b exp=0", presp[0].waitrequest); end
    drive(1, 0, 32'h10, 1, 0, 32'h20, 0, 32'h0);
    checks++; if (mreq.address !== 32'h20) begin failures++; $display("FAIL rr_c2_addr got=%h exp=00000020", mreq.address); end
    checks++; if (presp[0].waitrequest !== 1'b1) begin failures++; $display("FAIL rr_c2_wait0 got=%b exp=1", presp[0].waitrequest); end
  endtask
`else
  task automatic test_fixed_priority;
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 32'h10, 1, 0, 32'h20, 0, 32'h0);
      checks++; if (mreq.address !== 32'h10) begin failures++; $display("FAIL fp_addr c=%0d got=%h exp=00000010", c, mreq.address); end
      checks++; if (presp[1].waitrequest !== 1'b1) begin failures++; $display("FAIL fp_wait1 c=%0d got=%b exp=1", c, presp[1].waitrequest); end
    end
  endtask
`endif

  task automatic test_no_grant;
    drive(0, 0, 32'h77, 0, 0, 32'h88, 0, 32'h0);
    checks++; if (mreq.read !== 1'b0 || mreq.write !== 1'b0) begin failures++; $display("FAIL idle_rw got=%b%b exp=00", mreq.read, mreq.write); end
    checks++; if (mreq.address !== 32'h77) begin failures++; $display("FAIL idle_addr got=%h exp=00000077", mreq.address); end
    checks++; if (presp[0].waitrequest !== 1'b0 || presp[1].waitrequest !== 1'b0) begin failures++; $display("FAIL idle_wait got=%b%b exp=00", presp[0].waitrequest, presp[1].waitrequest); end
  endtask

  task automatic test_lock;
    drive(0, 0, 32'h0, 1, 0, 32'h100, 1, 32'h0);
    checks++; if (mreq.address !== 32'h100 || presp[1].waitrequest !== 1'b1) begin failures++; $display("FAIL lock_c1 got=%h/%b exp=00000100/1", mreq.address, presp[1].waitrequest); end
    for (int c = 2; c <= 3; c++) begin
      drive(1, 0, 32'h200, 1, 0, 32'h100, 1, 32'h0);
      checks++; if (mreq.address !== 32'h100) begin failures++; $display("FAIL lock_addr c=%0d got=%h exp=00000100", c, mreq.address); end
      checks++; if (presp[0].waitrequest !== 1'b1) begin failures++; $display("FAIL lock_wait0 c=%0d got=%b exp=1", c, presp[0].waitrequest); end
    end
    drive(1, 0, 32'h200, 1, 0, 32'h100, 0, 32'h0);
    checks++; if (mreq.address !== 32'h100 || presp[1].waitrequest !== 1'b0) begin failures++; $display("FAIL lock_done got=%h/%b exp=00000100/0", mreq.address, presp[1].waitrequest); end
    checks++; if (presp[0].waitrequest !== 1'b1) begin failures++; $display("FAIL lock_done_wait0 got=%b exp=1", presp[0].waitrequest); end
    drive(1, 0, 32'h200, 0, 0, 32'h0, 0, 32'hCAFE);
    checks++; if (presp[1].readdata !== 32'hCAFE) begin failures++; $display("FAIL lock_rdata1 got=%h exp=0000cafe", presp[1].readdata); end
    checks++; if (presp[0].readdata !== 32'h0) begin failures++; $display("FAIL lock_rdata0 got=%h exp=00000000", presp[0].readdata); end
    checks++; if (mreq.address !== 32'h200 || presp[0].waitrequest !== 1'b0) begin failures++; $display("FAIL lock_next got=%h/%b exp=00000200/0", mreq.address, presp[0].waitrequest); end
    drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h1234);
    checks++; if (presp[0].readdata !== 32'h1234) begin failures++; $display("FAIL lock_next_rdata got=%h exp=00001234", presp[0].readdata); end
  endtask

  task automatic test_back_to_back;
    drive(1, 0, 32'h300, 0, 0, 32'h0, 0, 32'h0);
    drive(0, 0, 32'h0, 1, 0, 32'h304, 0, 32'hAAAA);
    checks++; if (presp[0].readdata !== 32'hAAAA) begin failures++; $display("FAIL b2b_p0 got=%h exp=0000aaaa", presp[0].readdata); end
    checks++; if (presp[1].readdata !== 32'h0) begin failures++; $display("FAIL b2b_p1_early got=%h exp=00000000", presp[1].readdata); end
    drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h5555);
    checks++; if (presp[1].readdata !== 32'h5555) begin failures++; $display("FAIL b2b_p1 got=%h exp=00005555", presp[1].readdata); end
    checks++; if (presp[0].readdata !== 32'h0) begin failures++; $display("FAIL b2b_p0_late got=%h exp=00000000", presp[0].readdata); end
    drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h9999);
    checks++; if (presp[0].readdata !== 32'h0 || presp[1].readdata !== 32'h0) begin failures++; $display("FAIL b2b_none got=%h/%h exp=0/0", presp[0].readdata, presp[1].readdata); end
  endtask

  task automatic test_timeout;
    drive(0, 1, 32'h400, 0, 0, 32'h0, 1, 32'h0);
    checks++; if (tmo !== 1'b0 || mreq.write !== 1'b1) begin failures++; $display("FAIL to_idle got=%b/%b exp=0/1", tmo, mreq.write); end
    for (int c = 1; c <= 3; c++) begin
      drive(0, 1, 32'h400, 0, 0, 32'h0, 1, 32'h0);
      checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL to_early lockcyc=%0d got=%b exp=0", c, tmo); end
    end
    drive(0, 1, 32'h400, 0, 0, 32'h0, 1, 32'h0);
    checks++; if (tmo !== 1'b1) begin failures++; $display("FAIL to_pulse got=%b exp=1", tmo); end
    drive(0, 0, 32'h400, 0, 1, 32'h500, 0, 32'h0);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL to_single got=%b exp=0", tmo); end
    checks++; if (mreq.address !== 32'h500 || mreq.write !== 1'b1) begin failures++; $display("FAIL to_rearb got=%h/%b exp=00000500/1", mreq.address, mreq.write); end
    drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_reset_mid;
    drive(0, 0, 32'h0, 1, 0, 32'h600, 1, 32'h0);
    drive(0, 0, 32'h0, 1, 0, 32'h600, 1, 32'h0);
    rst_n = 1'b0;
    #1;
    checks++; if (presp[0].waitrequest !== 1'b1 || presp[1].waitrequest !== 1'b1) begin failures++; $display("FAIL midrst_wait got=%b%b exp=11", presp[0].waitrequest, presp[1].waitrequest); end
    checks++; if (mreq.read !== 1'b0) begin failures++; $display("FAIL midrst_read got=%b exp=0", mreq.read); end
    drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'hDEAD);
    rst_n = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'hDEAD);
    checks++; if (presp[1].readdata !== 32'h0 || mreq.read !== 1'b0) begin failures++; $display("FAIL midrst_stale got=%h/%b exp=0/0", presp[1].readdata, mreq.read); end
    // Accepted read, then reset lands in the data-return cycle.
    drive(1, 0, 32'h700, 0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    preq[0].read = 1'b0; mresp.readdata = 32'hBEEF;
    #1;
    checks++; if (presp[0].readdata !== 32'h0) begin failures++; $display("FAIL pendrst_rdata got=%h exp=00000000", presp[0].readdata); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'hBEEF);
    checks++; if (presp[0].readdata !== 32'h0) begin failures++; $display("FAIL pendrst_after got=%h exp=00000000", presp[0].readdata); end
  endtask

  initial begin
    rst_n = 1'b0;
    preq  = '0;
    mresp = '0;
    repeat (2) @(posedge clk);
    test_reset();
`ifdef ARB_ROUND_ROBIN_EN
    test_round_robin();
`else
    test_fixed_priority();
`endif
    test_no_grant();
    test_lock();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
